// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  typedef enum logic {PAR_EVEN, PAR_ODD} parity_mode_t;

  localparam int           UART_DATA_BITS        = 8;
  localparam int           UART_DEF_CLKS_PER_BIT = 5208;
  localparam parity_mode_t UART_PARITY_MODE      = PAR_EVEN;

  // 1 when the received parity bit disagrees with the configured mode.
  function automatic logic calcParityErr(input logic [UART_DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p ^ (UART_PARITY_MODE == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_parity.sv
// 8E1 UART receiver: start-bit validation, LSB-first data, even parity, stop check,
// sticky interrupt / parity / framing / overrun flags.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      serialDataRX,
  input  logic                      clearInterrupt,
  output logic [UART_DATA_BITS-1:0] receivedData,
  output logic                      rxInterrupt,
  output logic                      parityError,
  output logic                      framingError,
  output logic                      overrunError,
  output logic                      rxBusy
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  rx_state_t                 state, stateNext;
  logic [CW-1:0]             bitCnt, bitCntNext;
  logic [2:0]                bitIdx, bitIdxNext;
  logic [UART_DATA_BITS-1:0] shiftReg, shiftNext;
  logic                      parErr, parErrNext;
  logic                      rxS, rxPrev;
  logic                      frameOk, frameBad;

  uart_sync2 #(.RST_VAL(1'b1)) uSync (
    .clk (clk),
    .rst (rst),
    .d   (serialDataRX),
    .q   (rxS)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bitCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      parErr   <= 1'b0;
      rxPrev   <= 1'b1;
    end else begin
      state    <= stateNext;
      bitCnt   <= bitCntNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftNext;
      parErr   <= parErrNext;
      rxPrev   <= rxS;
    end
  end

  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt + 1'b1;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    parErrNext = parErr;
    frameOk    = 1'b0;
    frameBad   = 1'b0;
    case (state)
      IDLE: begin
        bitCntNext = '0;
        // a true 1->0 edge is required, so a line stuck low cannot retrigger
        if (rxPrev && !rxS) stateNext = START;
      end
      START: begin
        if (bitCnt == HALF) begin
          bitCntNext = '0;
          bitIdxNext = '0;
          stateNext  = rxS ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bitCnt == LAST) begin
          bitCntNext = '0;
          shiftNext  = {rxS, shiftReg[UART_DATA_BITS-1:1]};
          bitIdxNext = bitIdx + 1'b1;
          if (bitIdx == 3'd7) stateNext = PARITY;
        end
      end
      PARITY: begin
        if (bitCnt == LAST) begin
          bitCntNext = '0;
          parErrNext = calcParityErr(shiftReg, rxS);
          stateNext  = STOP;
        end
      end
      STOP: begin
        if (bitCnt == LAST) begin
          bitCntNext = '0;
          stateNext  = IDLE;
          frameOk    = rxS;
          frameBad   = !rxS;
        end
      end
      default: begin
        stateNext  = IDLE;
        bitCntNext = '0;
      end
    endcase
  end

  // Later assignments override the clear, so a completing frame wins over clearInterrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      receivedData <= '0;
      rxInterrupt  <= 1'b0;
      parityError  <= 1'b0;
      framingError <= 1'b0;
      overrunError <= 1'b0;
    end else begin
      if (clearInterrupt) begin
        rxInterrupt  <= 1'b0;
        parityError  <= 1'b0;
        framingError <= 1'b0;
        overrunError <= 1'b0;
      end
      if (frameOk) begin
        receivedData <= shiftReg;
        parityError  <= parErr;
        rxInterrupt  <= 1'b1;
        overrunError <= !clearInterrupt && (overrunError || rxInterrupt);
      end
      if (frameBad) framingError <= 1'b1;
    end
  end

  assign rxBusy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_parity.sv
// Randomized self-checking bench for uart_rx_parity against a frame-level reference model.
module tb_uart_rx_parity;

  localparam int N  = 16;
  localparam int H  = N / 2;
  localparam int ND = 5208;

  logic       clk = 1'b0;
  logic       rst, rxLineA, rxLineB, clrA, clrB;
  logic [7:0] dataA, dataB;
  logic       intA, parA, frmA, ovrA, busyA;
  logic       intB, parB, frmB, ovrB, busyB;

  always #5 clk = ~clk;

  uart_rx_parity #(.CLKS_PER_BIT(N)) dutA (
    .clk(clk), .rst(rst), .serialDataRX(rxLineA), .clearInterrupt(clrA),
    .receivedData(dataA), .rxInterrupt(intA), .parityError(parA),
    .framingError(frmA), .overrunError(ovrA), .rxBusy(busyA)
  );

  uart_rx_parity dutB (
    .clk(clk), .rst(rst), .serialDataRX(rxLineB), .clearInterrupt(clrB),
    .receivedData(dataB), .rxInterrupt(intB), .parityError(parB),
    .framingError(frmB), .overrunError(ovrB), .rxBusy(busyB)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation of DUT A: cycle of last output change and of busy edges.
  logic [11:0] prevObs  = '0;
  logic        prevBusy = 1'b0;
  int          chgCyc   = 0;
  int          busyRise = 0;
  int          busyFall = 0;

  always @(negedge clk) begin
    if ({dataA, intA, parA, frmA, ovrA} !== prevObs) chgCyc <= cyc;
    prevObs <= {dataA, intA, parA, frmA, ovrA};
    if (busyA && !prevBusy) busyRise <= cyc;
    if (!busyA && prevBusy) busyFall <= cyc;
    prevBusy <= busyA;
  end

  // Reference model state for DUT A
  logic [7:0] mData;
  logic       mInt, mPar, mFrm, mOvr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mData = 8'h00; mInt = 1'b0; mPar = 1'b0; mFrm = 1'b0; mOvr = 1'b0;
  endtask

  // Outcome of one whole frame from the line-level rules.
  task automatic modelFrame(input logic [7:0] d, input logic p, input logic s, input bit clr);
    logic hadInt;
    hadInt = mInt;
    if (clr) begin
      mInt = 1'b0; mPar = 1'b0; mFrm = 1'b0; mOvr = 1'b0;
    end
    if (s) begin
      mData = d;
      mPar  = (($countones(d) + int'(p)) % 2) != 0;
      mInt  = 1'b1;
      if (!clr && hadInt) mOvr = 1'b1;
    end else begin
      mFrm = 1'b1;
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, "_data"}, 32'(dataA), 32'(mData));
    chk({tag, "_int"},  32'(intA),  32'(mInt));
    chk({tag, "_par"},  32'(parA),  32'(mPar));
    chk({tag, "_frm"},  32'(frmA),  32'(mFrm));
    chk({tag, "_ovr"},  32'(ovrA),  32'(mOvr));
    chk({tag, "_busy"}, 32'(busyA), 32'd0);
  endtask

  task automatic doClear();
    clrA = 1'b1;
    tick();
    clrA = 1'b0;
    mInt = 1'b0; mPar = 1'b0; mFrm = 1'b0; mOvr = 1'b0;
  endtask

  // Drives start, 8 data bits LSB first, parity, stop; optionally pulses clearInterrupt
  // in the cycle whose edge commits the frame (t0+H+10N, t0 = pin edge + 3).
  task automatic sendFrame(input bit sel, input int n, input logic [7:0] d,
                           input logic p, input logic s, input bit clrAtDone);
    logic [10:0] bits;
    int          e0;
    bits = {s, p, d, 1'b0};
    e0   = cyc;
    for (int b = 0; b < 11; b++) begin
      for (int k = 0; k < n; k++) begin
        if (sel) rxLineB = bits[b];
        else     rxLineA = bits[b];
        clrA = clrAtDone && (cyc == e0 + 3 + n / 2 + 10 * n);
        tick();
      end
    end
    rxLineA = 1'b1;
    rxLineB = 1'b1;
    clrA    = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s;
    bit         c, cd;
    int         oldRise;

    rst = 1'b1; rxLineA = 1'b1; rxLineB = 1'b1; clrA = 1'b0; clrB = 1'b0;
    modelReset();
    repeat (3) tick();
    checkAll("reset");
    rst = 1'b0;
    repeat (4) tick();

    // good frame plus exact commit timing
    sendFrame(0, N, 8'hFE, 1'b1, 1'b1, 0);
    modelFrame(8'hFE, 1'b1, 1'b1, 0);
    tick();
    checkAll("fe");
    chk("fe_latency", 32'(chgCyc - busyRise), 32'(H + 10 * N + 1));
    chk("fe_busyfall", 32'(busyFall), 32'(chgCyc));

    // wrong parity
    doClear();
    sendFrame(0, N, 8'h03, 1'b1, 1'b1, 0);
    modelFrame(8'h03, 1'b1, 1'b1, 0);
    tick();
    checkAll("par03");

    // framing error
    sendFrame(0, N, 8'h5A, 1'b0, 1'b0, 0);
    modelFrame(8'h5A, 1'b0, 1'b0, 0);
    tick();
    checkAll("frm5a");

    // 3-cycle glitch on idle line
    oldRise = busyRise;
    rxLineA = 1'b0;
    repeat (3) tick();
    rxLineA = 1'b1;
    repeat (H + 8) tick();
    chk("glitch_rise", 32'(busyRise > oldRise), 32'd1);
    chk("glitch_fall", 32'((busyFall - busyRise) >= H - 1 && (busyFall - busyRise) <= H + 1), 32'd1);
    checkAll("glitch");

    // back-to-back overrun, then clear coinciding with completion
    doClear();
    sendFrame(0, N, 8'h11, 1'b0, 1'b1, 0);
    modelFrame(8'h11, 1'b0, 1'b1, 0);
    sendFrame(0, N, 8'h22, 1'b0, 1'b1, 0);
    modelFrame(8'h22, 1'b0, 1'b1, 0);
    tick();
    checkAll("b2b");
    sendFrame(0, N, 8'h33, 1'b0, 1'b1, 1);
    modelFrame(8'h33, 1'b0, 1'b1, 1);
    tick();
    checkAll("clrdone");

    // reset in the middle of data bit 4
    d = 8'hC3;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < ((b == 4) ? H : N); k++) begin
        rxLineA = (b == 0) ? 1'b0 : d[b-1];
        tick();
      end
    end
    rst = 1'b1; rxLineA = 1'b1;
    tick();
    modelReset();
    checkAll("midrst");
    rst = 1'b0;
    repeat (2 * N) tick();
    sendFrame(0, N, 8'hA5, 1'b0, 1'b1, 0);
    modelFrame(8'hA5, 1'b0, 1'b1, 0);
    tick();
    checkAll("a5");

    // randomized frames
    for (int i = 0; i < 12; i++) begin
      d  = 8'($urandom_range(0, 255));
      p  = ($urandom_range(0, 3) == 0) ? !(^d) : (^d);
      s  = ($urandom_range(0, 4) != 0);
      c  = ($urandom_range(0, 1) == 1);
      cd = ($urandom_range(0, 3) == 0);
      if (c) doClear();
      sendFrame(0, N, d, p, s, cd);
      modelFrame(d, p, s, cd);
      repeat ($urandom_range(1, 20)) tick();
      checkAll($sformatf("rnd%0d", i));
    end

    // one frame at the default bit rate
    sendFrame(1, ND, 8'h96, 1'b0, 1'b1, 0);
    repeat (5) tick();
    chk("def_data", 32'(dataB), 32'h96);
    chk("def_int",  32'(intB),  32'd1);
    chk("def_par",  32'(parB),  32'd0);
    chk("def_frm",  32'(frmB),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity.md
# uart_rx_parity

Serial receiver for the project UART link: 8 data bits, LSB first, one even-parity bit, one stop bit, 9600 baud from a 50 MHz clock by default. It deserializes `serialDataRX` into a byte and raises a sticky interrupt with parity and framing status for the bus-side logic in `uart_top`. It is the receiving end of the frame format produced by the transmitter and by the bench's byte-writer task.

## Interface
- `CLKS_PER_BIT`, 5208: clock cycles per serial bit; must be ≥ 4.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `serialDataRX`  in  1  asynchronous serial line; idles high.
- `clearInterrupt`  in  1  level; clears `rxInterrupt`, `parityError`, `framingError`, `overrunError`.
- `receivedData`  out  8  last good-framed byte.
- `rxInterrupt`  out  1  sticky; a byte is available.
- `parityError`  out  1  sticky; parity of the last accepted byte was wrong.
- `framingError`  out  1  sticky; a frame had stop bit = 0.
- `overrunError`  out  1  sticky; a byte was accepted while `rxInterrupt` was still set.
- `rxBusy`  out  1  high while the FSM is not IDLE.

## Operation
- Input path: 2-flop synchronizer produces `rx_s`. Both flops reset to 1, so reset never creates a false start.
- Define N = `CLKS_PER_BIT` and H = N/2 (integer division). One bit counter runs, width $clog2(N).
- FSM states and transitions:
  - IDLE: `rx_s` = 0 → START, counter cleared.
  - START: after H cycles, sample `rx_s`. If 0 → DATA. If 1 → IDLE (glitch rejected, no flags).
  - DATA: every N cycles, shift `rx_s` into bit[i], i = 0..7. After bit 7 → PARITY.
  - PARITY: after N cycles, sample p. Computed error = (^data) ^ p.
  - STOP: after N cycles, sample the stop bit, then → IDLE. Return happens mid stop bit, so back-to-back frames are supported.
- Stop bit = 1:
  - `receivedData` ← data.
  - `parityError` ← computed error (overwritten, not OR-ed).
  - `rxInterrupt` ← 1.
  - `overrunError` ← 1 if `rxInterrupt` was already 1.
- Stop bit = 0: `framingError` ← 1. `receivedData`, `rxInterrupt` and `parityError` are unchanged.
- `clearInterrupt` in the same cycle as frame completion: completion wins. The flags set by that frame are 1 and the others are cleared.
- `clearInterrupt` held high does not block reception.

## Timing
- Pin to `rx_s` latency: 2 cycles.
- Let t0 be the cycle the FSM leaves IDLE. Sample points:
  - start: t0+H
  - data bit i: t0+H+(i+1)·N
  - parity: t0+H+9N
  - stop: t0+H+10N
- Outputs update on the cycle after the stop sample. `rxBusy` falls in that same cycle.
- Reset values: `receivedData` = 0x00; `rxInterrupt`, `parityError`, `framingError`, `overrunError` = 0; `rxBusy` = 0; FSM in IDLE; counters 0.
- `rst` mid-frame: abort to IDLE with all outputs at their reset values. The partial byte is discarded. After release, the first valid start needs `rx_s` at 1 then 0.
- A line held low after a framing error restarts only after `rx_s` returns high (IDLE requires a 1→0 sample, tracked with a `rx_s` delay flop).

## Structure
- Package `uart_pkg`:
  - state enum `rx_state_t` {IDLE, START, DATA, PARITY, STOP}
  - `UART_DATA_BITS` = 8
  - `UART_DEF_CLKS_PER_BIT` = 5208
  - parity-mode constant fixed to EVEN
- Sub-module `uart_sync2`: 2-flop synchronizer with a reset value parameter (1 here). The transmitter-side bench loopback reuses it.
- Top-level contents: FSM, bit counter, index counter (3 bits), shift register, flag logic.

## Test plan
Use `CLKS_PER_BIT` = 16 (H = 8) for speed, plus one frame at the default 5208.
- Frame 0xFE, parity 1, stop 1 → `receivedData` = 0xFE, `rxInterrupt` = 1, `parityError` = 0. Outputs change exactly at t0+H+10N+1.
- Clear, then frame 0x03 with parity 1 (wrong) → `receivedData` = 0x03, `parityError` = 1, `rxInterrupt` = 1.
- Frame 0x5A with stop 0 → `framingError` = 1. `receivedData` keeps its previous value and `rxInterrupt` is unchanged.
- Low glitch of 3 cycles on an idle line → `rxBusy` high, then low at t0+H. No flags change.
- 0x11 then 0x22 back-to-back with no clear → `receivedData` = 0x22, `overrunError` = 1. Then `clearInterrupt` asserted in the completion cycle of a third frame 0x33 → `rxInterrupt` = 1, `overrunError` = 0.
- `rst` asserted at data bit 4 → all outputs at reset values next cycle. A following 0xA5 frame is received correctly.
